dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares the single data-memory/MMIO port between two requesters:
  - m0: the CPU load/store unit.
  - m1: the program/debug loader.
- Round-robin arbitration with an optional lock for multi-word transfers, and a registered read-response path.
- Protects the MMIO display register from loader writes.
- Sits between the requesters and the data memory; the memory's read is combinational on its address.

Parameters:
- ADDR_WIDTH, 10, word address width of the memory port.
- DATA_WIDTH, 32, data word width.
- MMIO_ADDR, 'h20, word address of the 7-segment MMIO register; loader writes here are blocked.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous active-high reset.
- m0_req  in  1  CPU access request, held until granted.
- m0_we  in  1  CPU write enable (qualifies request).
- m0_addr  in  ADDR_WIDTH  CPU word address.
- m0_wdata  in  DATA_WIDTH  CPU write data.
- m0_lock  in  1  CPU requests to keep ownership after this grant.
- m0_gnt  out  1  access accepted this cycle.
- m0_rvalid  out  1  read data valid (one cycle after a granted read).
- m0_rdata  out  DATA_WIDTH  registered read data.
- m1_req, m1_we, m1_addr, m1_wdata, m1_lock, m1_gnt, m1_rvalid, m1_rdata: same as m0, for the loader.
- m1_err  out  1  one-cycle pulse: loader write to MMIO_ADDR was dropped.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_WIDTH  memory address.
- mem_wdata  out  DATA_WIDTH  memory write data.
- mem_rdata  in  DATA_WIDTH  combinational read data from memory.

Behaviour:
State registers:
- prio: next preferred master.
- owner_valid / owner: lock state.
- rv0 / rv1 and rd0 / rd1: response registers.

Reset (asynchronous, takes effect immediately):
- prio=0, owner_valid=0, all rvalid=0, all rdata=0, m1_err=0.
- Combinational outputs follow: no gnt while no req; mem_we=0.

Arbitration (combinational on current req and registers):
- If owner_valid: only owner may be granted; the other master waits even if requesting.
- Else, only one req → grant it.
- Else, both req → grant the master == prio.
- At most one gnt per cycle; a gnt without a matching req never occurs.

Memory drive:
- mem_addr, mem_wdata and mem_we come from the granted master.
- With no grant: mem_we=0, mem_addr=0, mem_wdata=0.
- Granted m1 write with m1_addr==MMIO_ADDR: mem_we forced 0, m1_gnt still asserted, m1_err pulses next cycle.
- m0 writes to MMIO_ADDR pass through unchanged.

Priority update (at clock edge of any grant):
- prio <= other master.
- A locked grant does not change prio until the lock is released.

Lock:
- On a grant with mX_lock=1: owner_valid<=1, owner<=X.
- Lock released on the owner's next grant with mX_lock=0, or on a cycle where the owner has req=0. Either way: owner_valid<=0, prio<=other master.

Read response:
- A granted read (we=0) sets mX_rvalid=1 for exactly the next cycle, with mX_rdata <= mem_rdata sampled at the grant edge.
- rdata holds its value until the next granted read for that master.
- Back-to-back grants to one master give back-to-back rvalid pulses.
- Writes produce no rvalid.

Timing:
- Grant latency is 0 cycles when the port is free.
- Worst-case unlocked wait is 1 cycle.

Test Plan:
- Reset with both req=1 → grant follows only after rst deasserts. Assert rst mid-operation → rvalid, m1_err and owner_valid clear immediately; prio=0, so first contention grants m0.
- Single master: m0 writes 'hDEADBEEF to addr 5 → same-cycle m0_gnt, mem_we=1, mem_addr=5. m0 read addr 5 → m0_rvalid one cycle later with m0_rdata='hDEADBEEF.
- Both masters hold req for 4 reads (addrs 1..4 on m0, 9..12 on m1) → grants alternate m0,m1,m0,m1…; each rvalid lands on the correct master with the correct data.
- m1 asserts lock for 3 consecutive writes while m0 requests continuously → m1 granted 3 cycles in a row, m0_gnt=0 throughout, then m0 granted on the cycle after lock release.
- m1 writes 7 to MMIO_ADDR ('h20) → m1_gnt=1, mem_we=0, m1_err=1 for one cycle. m0 writes 7 to 'h20 → mem_we=1, m1_err=0.
- Locked owner drops req without a final unlocked access → lock released that cycle; m0 granted next.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Two-master round-robin arbiter for the shared data-memory/MMIO port.
// Supports a lock for multi-word bursts, registered read responses and a loader write guard on the MMIO register.
module dmem_arbiter #(
    parameter int                    ADDR_WIDTH = 10,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] MMIO_ADDR  = 'h20
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  m0_req,
    input  logic                  m0_we,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [DATA_WIDTH-1:0] m0_wdata,
    input  logic                  m0_lock,
    output logic                  m0_gnt,
    output logic                  m0_rvalid,
    output logic [DATA_WIDTH-1:0] m0_rdata,
    input  logic                  m1_req,
    input  logic                  m1_we,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [DATA_WIDTH-1:0] m1_wdata,
    input  logic                  m1_lock,
    output logic                  m1_gnt,
    output logic                  m1_rvalid,
    output logic [DATA_WIDTH-1:0] m1_rdata,
    output logic                  m1_err,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    // prio/owner encode the master index: 0 = CPU, 1 = loader
    logic                  prio_q, prio_d;
    logic                  owner_valid_q, owner_valid_d;
    logic                  owner_q, owner_d;
    logic                  rv0_q, rv0_d, rv1_q, rv1_d;
    logic [DATA_WIDTH-1:0] rd0_q, rd0_d, rd1_q, rd1_d;
    logic                  err_q, err_d;
    logic                  gnt0, gnt1, blocked, owner_req;

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!rst) begin
            if (owner_valid_q) begin
                gnt0 = !owner_q && m0_req;
                gnt1 = owner_q && m1_req;
            end else if (m0_req && m1_req) begin
                gnt0 = !prio_q;
                gnt1 = prio_q;
            end else begin
                gnt0 = m0_req;
                gnt1 = m1_req;
            end
        end
    end

    assign blocked   = gnt1 && m1_we && (m1_addr == MMIO_ADDR);
    assign owner_req = owner_q ? m1_req : m0_req;

    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (gnt0) begin
            mem_we    = m0_we;
            mem_addr  = m0_addr;
            mem_wdata = m0_wdata;
        end else if (gnt1) begin
            mem_we    = m1_we && !blocked;
            mem_addr  = m1_addr;
            mem_wdata = m1_wdata;
        end
    end

    always_comb begin
        prio_d        = prio_q;
        owner_valid_d = owner_valid_q;
        owner_d       = owner_q;
        // A locked grant takes ownership but leaves the round-robin pointer alone
        if (gnt0) begin
            if (m0_lock) begin
                owner_valid_d = 1'b1;
                owner_d       = 1'b0;
            end else begin
                owner_valid_d = 1'b0;
                prio_d        = 1'b1;
            end
        end
        if (gnt1) begin
            if (m1_lock) begin
                owner_valid_d = 1'b1;
                owner_d       = 1'b1;
            end else begin
                owner_valid_d = 1'b0;
                prio_d        = 1'b0;
            end
        end
        // Owner walked away mid-burst: free the port and favour the other master
        if (owner_valid_q && !owner_req) begin
            owner_valid_d = 1'b0;
            prio_d        = !owner_q;
        end
    end

    always_comb begin
        rv0_d = gnt0 && !m0_we;
        rv1_d = gnt1 && !m1_we;
        rd0_d = rv0_d ? mem_rdata : rd0_q;
        rd1_d = rv1_d ? mem_rdata : rd1_q;
        err_d = blocked;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio_q        <= 1'b0;
            owner_valid_q <= 1'b0;
            owner_q       <= 1'b0;
            rv0_q         <= 1'b0;
            rv1_q         <= 1'b0;
            rd0_q         <= '0;
            rd1_q         <= '0;
            err_q         <= 1'b0;
        end else begin
            prio_q        <= prio_d;
            owner_valid_q <= owner_valid_d;
            owner_q       <= owner_d;
            rv0_q         <= rv0_d;
            rv1_q         <= rv1_d;
            rd0_q         <= rd0_d;
            rd1_q         <= rd1_d;
            err_q         <= err_d;
        end
    end

    assign m0_gnt    = gnt0;
    assign m1_gnt    = gnt1;
    assign m0_rvalid = rv0_q;
    assign m1_rvalid = rv1_q;
    assign m0_rdata  = rd0_q;
    assign m1_rdata  = rd1_q;
    assign m1_err    = err_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural memory preloaded with 'hA0000000 + address.
module tb_dmem_arbiter;

    logic        clk, rst;
    logic        m0_req, m0_we, m0_lock, m1_req, m1_we, m1_lock;
    logic [9:0]  m0_addr, m1_addr, mem_addr;
    logic [31:0] m0_wdata, m1_wdata, mem_wdata, mem_rdata, m0_rdata, m1_rdata;
    logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid, m1_err, mem_we;
    logic [31:0] mem [0:1023];
    int          n_checks = 0;
    int          n_errors = 0;

    dmem_arbiter dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_lock(m0_lock),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_lock(m1_lock),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_err(m1_err),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) if (mem_we) mem[mem_addr] = mem_wdata;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end else begin
            $display("ok   %s = %0h", tag, obs);
        end
    endtask

    task automatic drv0(input logic r, input logic w, input logic [9:0] a, input logic [31:0] d, input logic l);
        m0_req = r; m0_we = w; m0_addr = a; m0_wdata = d; m0_lock = l;
    endtask

    task automatic drv1(input logic r, input logic w, input logic [9:0] a, input logic [31:0] d, input logic l);
        m1_req = r; m1_we = w; m1_addr = a; m1_wdata = d; m1_lock = l;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic gnts(input string tag, input logic g0, input logic g1);
        check({tag, ".m0_gnt"}, m0_gnt, g0);
        check({tag, ".m1_gnt"}, m1_gnt, g1);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'hA000_0000 + i;
        rst = 1'b1;
        drv0(1, 0, 10'd1, 0, 0);
        drv1(1, 0, 10'd9, 0, 0);
        #2;
        // Reset held with both requesting: nothing granted, all registers clear
        @(negedge clk);
        gnts("rst", 0, 0);
        check("rst.mem_we", mem_we, 0);
        check("rst.m0_rvalid", m0_rvalid, 0);
        check("rst.m1_rvalid", m1_rvalid, 0);
        check("rst.m0_rdata", m0_rdata, 0);
        check("rst.m1_err", m1_err, 0);
        next_cycle();
        rst = 1'b0;

        // Contention: grants alternate, responses land on the right master
        for (int i = 0; i < 4; i++) begin
            drv0(1, 0, 10'(1 + i), 0, 0);
            drv1(1, 0, 10'(9 + i), 0, 0);
            @(negedge clk);
            gnts($sformatf("rr%0d.a", i), 1, 0);
            check($sformatf("rr%0d.a.addr", i), mem_addr, 10'(1 + i));
            if (i > 0) begin
                check($sformatf("rr%0d.a.m1_rvalid", i), m1_rvalid, 1);
                check($sformatf("rr%0d.a.m1_rdata", i), m1_rdata, 32'hA000_0009 + i - 1);
            end
            check($sformatf("rr%0d.a.m0_rvalid", i), m0_rvalid, 0);
            next_cycle();
            @(negedge clk);
            gnts($sformatf("rr%0d.b", i), 0, 1);
            check($sformatf("rr%0d.b.addr", i), mem_addr, 10'(9 + i));
            check($sformatf("rr%0d.b.m0_rvalid", i), m0_rvalid, 1);
            check($sformatf("rr%0d.b.m0_rdata", i), m0_rdata, 32'hA000_0001 + i);
            check($sformatf("rr%0d.b.m1_rvalid", i), m1_rvalid, 0);
            next_cycle();
        end
        drv0(0, 0, 0, 0, 0);
        drv1(0, 0, 0, 0, 0);
        @(negedge clk);
        gnts("rr.idle", 0, 0);
        check("rr.idle.m1_rvalid", m1_rvalid, 1);
        check("rr.idle.m1_rdata", m1_rdata, 32'hA000_000C);
        check("rr.idle.mem_addr", mem_addr, 0);
        next_cycle();

        // Single master write then read-back
        drv0(1, 1, 10'd5, 32'hDEADBEEF, 0);
        @(negedge clk);
        gnts("wr", 1, 0);
        check("wr.mem_we", mem_we, 1);
        check("wr.mem_addr", mem_addr, 5);
        check("wr.mem_wdata", mem_wdata, 32'hDEADBEEF);
        next_cycle();
        drv0(1, 0, 10'd5, 0, 0);
        @(negedge clk);
        gnts("rd", 1, 0);
        check("rd.mem_we", mem_we, 0);
        check("rd.no_rvalid_after_write", m0_rvalid, 0);
        next_cycle();
        drv0(0, 0, 0, 0, 0);
        @(negedge clk);
        check("rd.m0_rvalid", m0_rvalid, 1);
        check("rd.m0_rdata", m0_rdata, 32'hDEADBEEF);
        next_cycle();
        @(negedge clk);
        check("rd.rvalid_pulse", m0_rvalid, 0);
        check("rd.rdata_hold", m0_rdata, 32'hDEADBEEF);
        next_cycle();

        // Loader burst of three locked writes while CPU keeps requesting (prio is now loader)
        for (int i = 0; i < 3; i++) begin
            drv0(1, 0, 10'd3, 0, 0);
            drv1(1, 1, 10'(100 + i), 32'h100 + i, (i < 2));
            @(negedge clk);
            gnts($sformatf("lock%0d", i), 0, 1);
            check($sformatf("lock%0d.mem_we", i), mem_we, 1);
            check($sformatf("lock%0d.mem_addr", i), mem_addr, 10'(100 + i));
            next_cycle();
        end
        drv1(1, 1, 10'd103, 32'h103, 0);
        @(negedge clk);
        gnts("lock.after", 1, 0);
        next_cycle();
        drv0(0, 0, 0, 0, 0);
        @(negedge clk);
        gnts("lock.after2", 0, 1);
        check("lock.m0_rdata", m0_rdata, 32'hA000_0003);
        check("lock.mem102", mem[102], 32'h102);
        next_cycle();
        drv1(0, 0, 0, 0, 0);

        // MMIO guard: loader write dropped with an error pulse, CPU write passes
        drv1(1, 1, 10'h20, 32'd7, 0);
        @(negedge clk);
        gnts("mmio1", 0, 1);
        check("mmio1.mem_we", mem_we, 0);
        check("mmio1.m1_err_early", m1_err, 0);
        next_cycle();
        drv1(0, 0, 0, 0, 0);
        @(negedge clk);
        check("mmio1.m1_err", m1_err, 1);
        check("mmio1.m1_rvalid", m1_rvalid, 0);
        next_cycle();
        drv0(1, 1, 10'h20, 32'd7, 0);
        @(negedge clk);
        check("mmio1.err_pulse", m1_err, 0);
        gnts("mmio0", 1, 0);
        check("mmio0.mem_we", mem_we, 1);
        check("mmio0.mem_addr", mem_addr, 10'h20);
        next_cycle();
        drv0(0, 0, 0, 0, 0);
        @(negedge clk);
        check("mmio0.m1_err", m1_err, 0);
        check("mmio0.mem20", mem[32], 7);
        next_cycle();

        // Locked owner drops its request: port freed, CPU granted on the following cycle
        drv0(1, 0, 10'd4, 0, 0);
        drv1(1, 0, 10'd9, 0, 1);
        @(negedge clk);
        gnts("drop.lock", 0, 1);
        next_cycle();
        drv1(0, 0, 0, 0, 0);
        @(negedge clk);
        gnts("drop.idle", 0, 0);
        check("drop.m1_rvalid", m1_rvalid, 1);
        check("drop.m1_rdata", m1_rdata, 32'hA000_0009);
        next_cycle();
        @(negedge clk);
        gnts("drop.m0", 1, 0);
        next_cycle();

        // Reset mid-burst clears responses and ownership immediately
        drv0(1, 0, 10'd6, 0, 0);
        drv1(1, 0, 10'd11, 0, 1);
        @(negedge clk);
        gnts("mid.lock", 0, 1);
        next_cycle();
        check("mid.m1_rvalid_pre", m1_rvalid, 1);
        rst = 1'b1;
        #1;
        check("mid.m1_rvalid", m1_rvalid, 0);
        check("mid.m1_rdata", m1_rdata, 0);
        check("mid.m0_rdata", m0_rdata, 0);
        check("mid.m1_err", m1_err, 0);
        gnts("mid.rst", 0, 0);
        next_cycle();
        rst = 1'b0;
        drv1(1, 0, 10'd11, 0, 0);
        @(negedge clk);
        gnts("mid.after", 1, 0);
        next_cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
